riscv_multicycle_core: RTL and testbench
========================================

# riscv_multicycle_core

Parametrised multi-cycle successor to the single-cycle RV32 top. It executes an RV32I integer subset through a fetch/decode/execute/memory/writeback state machine. All instruction and data traffic shares one external word-wide memory port with a req/ack handshake that tolerates wait states. It exposes writeback data, a retire counter and a halt flag, and is the core the team's SoC wrapper instantiates.

## Interface
- WIDTH, 32: datapath width; only 32 is supported (RV32).
- NUM_REGS, 32: architectural registers; 32 (RV32I) or 16 (RV32E, rs/rd bit 4 ignored → illegal).
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_req  output  1  memory request; held high until accepted.
- mem_we  output  1  1 = word store, 0 = word load/fetch.
- mem_addr  output  WIDTH  byte address; always word-aligned.
- mem_wdata  output  WIDTH  store data.
- mem_rdata  input  WIDTH  load/fetch data, valid in the ack cycle.
- mem_ack  input  1  transfer completes in a cycle where mem_req && mem_ack.
- rd  output  WIDTH  last value written to the register file.
- rd_valid  output  1  one-cycle pulse on each register write (x0 excluded).
- pc  output  WIDTH  PC of the current instruction.
- instret  output  WIDTH  retired-instruction count; wraps modulo 2^WIDTH.
- halted  output  1  sticky; set on illegal instruction or misalignment.

## Operation
- Supported: LUI, JAL, BEQ/BNE/BLT/BGE/BLTU/BGEU, LW, SW, OP-IMM (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI), OP (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND). All other encodings → HALT.
- States: FETCH → DECODE → EXEC → {MEM, WB, FETCH}; MEM → {WB, FETCH}; HALT (absorbing until rst).
- FETCH: drive mem_req=1, mem_we=0, mem_addr=pc. On ack, latch the instruction and go to DECODE.
- DECODE: read rs1/rs2, build the immediate, check legality. Illegal → HALT.
- EXEC:
  - Compute the ALU result / effective address / branch condition. Shifts use the low 5 bits of the operand. SLT is signed; SLTU is unsigned. Arithmetic wraps modulo 2^32.
  - Branch: next_pc = taken ? pc+imm : pc+4, then FETCH.
  - JAL: link = pc+4, next_pc = pc+imm, then WB.
  - LW/SW: go to MEM.
- MEM: mem_req=1, mem_we=SW, mem_addr=rs1+imm, mem_wdata=rs2. On ack: LW → WB; SW → FETCH.
- WB: write rd (writes to x0 are discarded; no rd_valid), then FETCH.
- Retire: pc ← next_pc and instret += 1 on the last cycle of each instruction.
- Misalignment is checked in EXEC and goes to HALT without retiring: nonzero addr[1:0] on LW/SW, or a taken branch/JAL target with target[1:0]≠0.
- HALT: mem_req=0; pc frozen at the offending instruction.

## Timing
- Reset values: pc=RESET_PC, state=FETCH, all registers 0, rd=0, rd_valid=0, instret=0, halted=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- mem_req is registered. It rises on the first cycle of FETCH/MEM and falls on the edge after the ack. Address, we and wdata stay stable while req is high.
- Latency with zero-wait memory (ack in the first req cycle):
  - branch: 3 cycles
  - OP/OP-IMM/LUI/JAL/SW: 4 cycles
  - LW: 5 cycles
  - Each extra wait cycle adds 1.
- rd/rd_valid update on the WB edge. instret is visible the cycle after retire.
- rst during a pending request: mem_req is 0 on the next cycle, and any in-flight store is abandoned; the memory must drop it.
- mem_ack without mem_req is ignored.

## Structure
- Package riscv_pkg: opcode constants, funct3/funct7 constants, state enum (FETCH, DECODE, EXEC, MEM, WB, HALT), ALU-op enum, immediate-format enum.
- Sub-module rv_regfile: NUM_REGS×WIDTH, 2 combinational read ports, 1 synchronous write port, x0 hard-wired 0, synchronous reset clears all entries.
- ALU and immediate decode are inline in the core.

## Test plan
- Zero-wait program ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2 → rd=5, 0xFFFFFFFD, 2. instret=3 at cycle 12.
- SW x3,0x40(x0) then LW x4,0x40(x0), with 2 wait cycles per access → store beat at addr 0x40, wdata 2; rd=2 on x4; LW takes 7 cycles.
- BLT x2,x1,+8 with x2=-3, x1=5 → taken, pc advances by 8. BLTU on the same operands → not taken, pc+4.
- JAL x1,+16 at pc 0x100 → rd=0x104, next fetch at 0x110. JAL x0 → no rd_valid.
- Illegal word 0x0000_0000, and LW with address 0x42 → halted=1, mem_req stays 0, pc frozen, instret unchanged.
- rst asserted while mem_req=1 awaiting ack → next cycle mem_req=0, pc=RESET_PC, instret=0, first fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings, FSM states and decode helpers for the multi-cycle RV32I core.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_fmt_e f);
    case (f)
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  // alt selects SUB/SRA; OP-IMM callers only pass it for the shift-right case
  function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv_regfile.sv
// Architectural register file: two async read ports, one sync write port, x0 reads zero.
module rv_regfile #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(NUM_REGS)-1:0] ra1,
  input  logic [$clog2(NUM_REGS)-1:0] ra2,
  input  logic [$clog2(NUM_REGS)-1:0] wa,
  input  logic                        we,
  input  logic [WIDTH-1:0]            wd,
  output logic [WIDTH-1:0]            rd1,
  output logic [WIDTH-1:0]            rd2
);

  logic [WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I-subset core; instruction and data traffic share one req/ack word port.
module riscv_multicycle_core
  import riscv_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               NUM_REGS = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic [WIDTH-1:0] rd,
  output logic             rd_valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] instret,
  output logic             halted
);

  localparam int AW = $clog2(NUM_REGS);

  state_e           state, state_nx;
  logic [31:0]      instr;
  logic [6:0]       opc, f7;
  logic [2:0]       f3;
  logic [WIDTH-1:0] res, npc_q, rs1v, rs2v, imm, op_b, alu_y, ea, target, pc4, npc_calc, pc_nx;
  logic             legal, use_rs1, use_rs2, use_rd, br_taken, xfer, retire, wb_en;
  imm_fmt_e         fmt;
  alu_op_e          alu_op;

  assign opc  = instr[6:0];
  assign f3   = instr[14:12];
  assign f7   = instr[31:25];
  assign xfer = mem_req && mem_ack;

  rv_regfile #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) u_rf (
    .clk(clk), .rst(rst),
    .ra1(instr[15 +: AW]), .ra2(instr[20 +: AW]), .wa(instr[7 +: AW]),
    .we(wb_en), .wd(res), .rd1(rs1v), .rd2(rs2v)
  );

  always_comb begin
    legal   = 1'b0;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    fmt     = IMM_I;
    alu_op  = ALU_ADD;
    case (opc)
      OPC_LUI:    begin legal = 1'b1; use_rs1 = 1'b0; use_rd = 1'b1; fmt = IMM_U; alu_op = ALU_PASSB; end
      OPC_JAL:    begin legal = 1'b1; use_rs1 = 1'b0; use_rd = 1'b1; fmt = IMM_J; end
      OPC_BRANCH: begin legal = (f3[2:1] != 2'b01); use_rs2 = 1'b1; fmt = IMM_B; end
      OPC_LOAD:   begin legal = (f3 == F3_W); use_rd = 1'b1; end
      OPC_STORE:  begin legal = (f3 == F3_W); use_rs2 = 1'b1; fmt = IMM_S; end
      OPC_OPIMM: begin
        use_rd = 1'b1;
        legal  = (f3 == F3_SLL) ? (f7 == F7_BASE) :
                 (f3 == F3_SR)  ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1;
        alu_op = alu_sel(f3, f3 == F3_SR && f7[5]);
      end
      OPC_OP: begin
        use_rd  = 1'b1;
        use_rs2 = 1'b1;
        legal   = (f7 == F7_BASE) || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
        alu_op  = alu_sel(f3, f7[5]);
      end
      default: ;
    endcase
    // RV32E: any referenced register index >= 16 is an illegal encoding
    if (NUM_REGS < 32 && ((use_rd && instr[11]) || (use_rs1 && instr[19]) || (use_rs2 && instr[24])))
      legal = 1'b0;
  end

  assign imm  = imm_gen(instr, fmt);
  assign op_b = (opc == OPC_OP) ? rs2v : imm;

  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD:   alu_y = rs1v + op_b;
      ALU_SUB:   alu_y = rs1v - op_b;
      ALU_SLL:   alu_y = rs1v << op_b[4:0];
      ALU_SLT:   alu_y = {{(WIDTH-1){1'b0}}, $signed(rs1v) < $signed(op_b)};
      ALU_SLTU:  alu_y = {{(WIDTH-1){1'b0}}, rs1v < op_b};
      ALU_XOR:   alu_y = rs1v ^ op_b;
      ALU_SRL:   alu_y = rs1v >> op_b[4:0];
      ALU_SRA:   alu_y = $signed(rs1v) >>> op_b[4:0];
      ALU_OR:    alu_y = rs1v | op_b;
      ALU_AND:   alu_y = rs1v & op_b;
      default:   alu_y = op_b;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (f3)
      F3_BEQ:  br_taken = (rs1v == rs2v);
      F3_BNE:  br_taken = (rs1v != rs2v);
      F3_BLT:  br_taken = ($signed(rs1v) < $signed(rs2v));
      F3_BGE:  br_taken = ($signed(rs1v) >= $signed(rs2v));
      F3_BLTU: br_taken = (rs1v < rs2v);
      F3_BGEU: br_taken = (rs1v >= rs2v);
      default: br_taken = 1'b0;
    endcase
  end

  assign ea       = rs1v + imm;
  assign target   = pc + imm;
  assign pc4      = pc + WIDTH'(4);
  assign npc_calc = ((opc == OPC_BRANCH && br_taken) || opc == OPC_JAL) ? target : pc4;

  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    wb_en    = 1'b0;
    case (state)
      FETCH:  if (xfer) state_nx = DECODE;
      DECODE: state_nx = legal ? EXEC : HALT;
      EXEC: begin
        case (opc)
          OPC_BRANCH: begin
            if (br_taken && target[1:0] != 2'b00) state_nx = HALT;
            else begin state_nx = FETCH; retire = 1'b1; end
          end
          OPC_JAL:             state_nx = (target[1:0] != 2'b00) ? HALT : WB;
          OPC_LOAD, OPC_STORE: state_nx = (ea[1:0] != 2'b00) ? HALT : MEM;
          default:             state_nx = WB;
        endcase
      end
      MEM: begin
        if (xfer) begin
          if (opc == OPC_STORE) begin state_nx = FETCH; retire = 1'b1; end
          else state_nx = WB;
        end
      end
      WB: begin
        state_nx = FETCH;
        retire   = 1'b1;
        wb_en    = (instr[11:7] != 5'd0);
      end
      default: state_nx = HALT;
    endcase
  end

  // branches retire straight out of EXEC, before npc_q has been captured
  assign pc_nx = !retire ? pc : (state == EXEC) ? npc_calc : npc_q;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      instr     <= '0;
      res       <= '0;
      npc_q     <= '0;
      rd        <= '0;
      rd_valid  <= 1'b0;
      instret   <= '0;
      halted    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      pc       <= pc_nx;
      rd_valid <= wb_en;
      if (retire) instret <= instret + WIDTH'(1);
      if (wb_en) rd <= res;
      if (state == FETCH && xfer) instr <= mem_rdata;
      if (state == EXEC) begin
        res   <= (opc == OPC_JAL) ? pc4 : alu_y;
        npc_q <= npc_calc;
      end
      if (state == MEM && xfer) res <= mem_rdata;
      if (state_nx == HALT) halted <= 1'b1;
      // request is launched on the edge entering FETCH/MEM and held until the ack edge
      mem_req  <= (state_nx == FETCH) || (state_nx == MEM);
      mem_we   <= (state_nx == MEM) && (opc == OPC_STORE);
      mem_addr <= (state_nx == MEM) ? ea : pc_nx;
      if (state_nx == MEM) mem_wdata <= rs2v;
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed bench: small program over a wait-state memory model, halt cases and reset mid-request.
module tb_riscv_multicycle_core;

  logic        clk, rst;
  logic        mem_req, mem_we, mem_ack, rd_valid, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, rd, pc, instret;

  int checks = 0;
  int errors = 0;
  int fwait = 0, dwait = 0, wcnt = 0, cur_wait, cyc = 0, st_cnt = 0;
  logic        kill0 = 1'b0;
  logic [31:0] dmem = 32'hDEAD_BEEF;
  logic [31:0] st_addr = '0, st_data = '0;
  logic [31:0] rdlog[$];
  int          fcyc[int];
  logic [31:0] finst[int];

  riscv_multicycle_core #(.WIDTH(32), .NUM_REGS(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rd(rd),
    .rd_valid(rd_valid), .pc(pc), .instret(instret), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rdi, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rdi, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rdi);
    return {f7, rs2, rs1, f3, rdi, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rdi);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rdi, 7'b1101111};
  endfunction

  function automatic logic [31:0] prog(input logic [31:0] a, input logic k0);
    case (a)
      32'h000: return k0 ? 32'h0 : enc_i(32'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
      32'h004: return enc_i(-32'sd3, 5'd0, 3'b000, 5'd2, 7'b0010011);
      32'h008: return enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3);
      32'h00C: return enc_s(32'h40, 5'd3, 5'd0);
      32'h010: return enc_i(32'h40, 5'd0, 3'b010, 5'd4, 7'b0000011);
      32'h014: return enc_b(32'd8, 5'd1, 5'd2, 3'b100);
      32'h018: return enc_i(32'd1, 5'd0, 3'b000, 5'd5, 7'b0010011);
      32'h01C: return enc_b(32'd8, 5'd1, 5'd2, 3'b110);
      32'h020: return enc_j(32'hE0, 5'd0);
      32'h100: return enc_j(32'd16, 5'd1);
      32'h110: return enc_i(32'h42, 5'd0, 3'b010, 5'd6, 7'b0000011);
      default: return 32'h0;
    endcase
  endfunction

  // memory: region 0x40-0x7F is data with dwait wait states, everything else fetch with fwait
  always_comb cur_wait = (mem_addr[9:6] == 4'd1) ? dwait : fwait;
  assign mem_ack = mem_req && (wcnt == cur_wait);
  always_comb mem_rdata = (mem_addr == 32'h40) ? dmem : prog(mem_addr, kill0);

  always @(posedge clk) begin
    wcnt <= (rst || !mem_req || mem_ack) ? 0 : wcnt + 1;
    cyc  <= cyc + 1;
  end

  always @(negedge clk) begin
    if (mem_req && mem_ack && mem_we) begin
      dmem    = mem_wdata;
      st_cnt  = st_cnt + 1;
      st_addr = mem_addr;
      st_data = mem_wdata;
    end
    if (mem_req && mem_ack && !mem_we) begin
      fcyc[int'(mem_addr)]  = cyc;
      finst[int'(mem_addr)] = instret;
    end
    if (rd_valid) rdlog.push_back(rd);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_halt(input int maxc);
    for (int i = 0; i < maxc && halted !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic idle_reqs(output int n);
    n = 0;
    repeat (10) begin @(negedge clk); if (mem_req) n++; end
  endtask

  initial begin
    int n, base_st, base_rd;
    logic seen;

    rst = 1'b1; fwait = 0; dwait = 2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instret", instret, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_req", {31'b0, mem_req}, 32'h0);
    chk("rst_we", {31'b0, mem_we}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rd", rd, 32'h0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
    rst = 1'b0;

    wait_halt(300);
    chk("prog_halted", {31'b0, halted}, 32'h1);
    chk("rd_count", rdlog.size(), 32'd5);
    if (rdlog.size() == 5) begin
      chk("rd_x1_addi", rdlog[0], 32'h5);
      chk("rd_x2_addi", rdlog[1], 32'hFFFF_FFFD);
      chk("rd_x3_add", rdlog[2], 32'h2);
      chk("rd_x4_lw", rdlog[3], 32'h2);
      chk("rd_x1_jal", rdlog[4], 32'h104);
    end
    chk("st_count", st_cnt, 32'd1);
    chk("st_addr", st_addr, 32'h40);
    chk("st_data", st_data, 32'h2);
    chk("lat_addi", fcyc[32'h4] - fcyc[32'h0], 32'd4);
    chk("cyc12_three_instr", fcyc[32'hC] - fcyc[32'h0], 32'd12);
    chk("instret_at_cyc12", finst[32'hC], 32'd3);
    chk("lat_sw_2wait", fcyc[32'h10] - fcyc[32'hC], 32'd6);
    chk("lat_lw_2wait", fcyc[32'h14] - fcyc[32'h10], 32'd7);
    chk("blt_skip_fetch", {31'b0, fcyc.exists(32'h18) != 0}, 32'h0);
    chk("lat_blt_taken", fcyc[32'h1C] - fcyc[32'h14], 32'd3);
    chk("lat_bltu_fall", fcyc[32'h20] - fcyc[32'h1C], 32'd3);
    chk("lat_jal_x0", fcyc[32'h100] - fcyc[32'h20], 32'd4);
    chk("lat_jal_x1", fcyc[32'h110] - fcyc[32'h100], 32'd4);
    idle_reqs(n);
    chk("misalign_no_req", n, 32'd0);
    chk("misalign_pc", pc, 32'h110);
    chk("misalign_instret", instret, 32'd9);
    chk("misalign_no_store", st_cnt, 32'd1);

    // illegal all-zero word at the reset vector
    kill0 = 1'b1; dwait = 0;
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base_rd = rdlog.size();
    wait_halt(50);
    chk("illegal_halted", {31'b0, halted}, 32'h1);
    chk("illegal_pc", pc, 32'h0);
    chk("illegal_instret", instret, 32'h0);
    idle_reqs(n);
    chk("illegal_no_req", n, 32'd0);
    chk("illegal_no_wb", rdlog.size() - base_rd, 32'd0);

    // reset while the SW request is stalled
    kill0 = 1'b0; dwait = 50;
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base_st = st_cnt;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) seen = 1'b1;
    end
    chk("pend_store_seen", {31'b0, seen}, 32'h1);
    chk("pend_instret", instret, 32'd3);
    chk("pend_addr", mem_addr, 32'h40);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("pend_rst_req", {31'b0, mem_req}, 32'h0);
    chk("pend_rst_pc", pc, 32'h0);
    chk("pend_rst_instret", instret, 32'h0);
    chk("pend_rst_halted", {31'b0, halted}, 32'h0);
    @(negedge clk);
    rst = 1'b0; dwait = 0;
    chk("pend_store_dropped", st_cnt - base_st, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    chk("refetch_req", {31'b0, seen}, 32'h1);
    chk("refetch_addr", mem_addr, 32'h0);
    chk("refetch_we", {31'b0, mem_we}, 32'h0);
    wait_halt(300);
    chk("rerun_instret", instret, 32'd9);
    chk("rerun_pc", pc, 32'h110);
    chk("rerun_store", st_cnt - base_st, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
